// File: rtl/mon_pkg.sv
// Shared types and constants for the data-memory write monitor.
package mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  localparam int MON_WIDTH_DEFAULT      = 32;
  localparam int MON_IGNORE_ADR_DEFAULT = 96;

  typedef struct packed {
    logic [MON_WIDTH_DEFAULT-1:0] adr;
    logic [MON_WIDTH_DEFAULT-1:0] data;
  } mon_entry_t;

  // Index width for a DEPTH-entry table, never narrower than one bit.
  function automatic int mon_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mon_exp_table.sv
// Expected-write table: DEPTH (address, data) entries, synchronous write,
// combinational read, synchronous active-low clear of every entry.
module mon_exp_table
  import mon_pkg::*;
#(
  parameter int WIDTH = MON_WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  localparam int IDX_W = mon_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [WIDTH-1:0] i_wadr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [WIDTH-1:0] o_radr,
  output logic [WIDTH-1:0] o_rdata
);

  typedef struct packed {
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t r_mem [DEPTH];
  entry_t w_rd;

  // Indices at or beyond DEPTH match no entry, so such writes are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!i_clr_n) begin
        r_mem[i] <= '0;
      end else if (i_we && (i_widx == IDX_W'(i))) begin
        r_mem[i] <= {i_wadr, i_wdata};
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_ridx == IDX_W'(i)) begin
        w_rd = r_mem[i];
      end
    end
  end

  assign o_radr  = w_rd.adr;
  assign o_rdata = w_rd.data;

endmodule

// File: rtl/mem_write_monitor.sv
// Matches core data-memory writes against an ordered expected table and
// raises sticky pass/fail/timeout flags. MISMATCH_CAPTURE_EN adds bad_* capture.
module mem_write_monitor
  import mon_pkg::*;
#(
  parameter int               WIDTH          = MON_WIDTH_DEFAULT,
  parameter int               DEPTH          = 4,
  parameter int               TIMEOUT_CYCLES = 1000,
  parameter int               IGNORE_EN      = 1,
  parameter logic [WIDTH-1:0] IGNORE_ADR     = WIDTH'(MON_IGNORE_ADR_DEFAULT),
  localparam int              IDX_W          = mon_idx_w(DEPTH),
  localparam int              CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] data_adr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [WIDTH-1:0] exp_adr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [CNT_W-1:0] exp_count,
  input  logic             start,
  input  logic             clear,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [31:0]      cycles,
  output mon_state_e       dbg_state
`ifdef MISMATCH_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] bad_adr,
  output logic [WIDTH-1:0] bad_data,
  output logic [IDX_W-1:0] bad_idx
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] w_match_nxt;
  logic [CNT_W-1:0] r_exp_cnt;
  logic [CNT_W-1:0] w_cnt_clip;
  logic [31:0]      r_cycles;
  logic [31:0]      w_cycles_nxt;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [WIDTH-1:0] w_exp_adr;
  logic [WIDTH-1:0] w_exp_data;
  logic             w_ignore;
  logic             w_hit;
  logic             w_start_go;
  logic             w_tab_we;

  assign w_cnt_clip = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  assign w_ignore   = (IGNORE_EN != 0) && (data_adr == IGNORE_ADR);
  assign w_hit      = (data_adr == w_exp_adr) && (write_data == w_exp_data);
  assign w_tab_we   = exp_we && (r_state == ST_IDLE);

  mon_exp_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .i_clr_n (reset),
    .i_we    (w_tab_we),
    .i_widx  (exp_idx),
    .i_wadr  (exp_adr),
    .i_wdata (exp_data),
    .i_ridx  (r_match_cnt[IDX_W-1:0]),
    .o_radr  (w_exp_adr),
    .o_rdata (w_exp_data)
  );

  // Control handshake: start is a one-cycle request, taken in any state other
  // than ARMED when clear is low; done is a level held until the next taken
  // start, a clear, or reset. clear always wins over start.
  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match_cnt;
    w_cycles_nxt = r_cycles;
    w_start_go   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (start && (r_state != ST_ARMED)) begin
      w_start_go   = 1'b1;
      w_match_nxt  = '0;
      w_cycles_nxt = '0;
      w_state_nxt  = (w_cnt_clip == '0) ? ST_PASS : ST_ARMED;
    end else if (r_state == ST_ARMED) begin
      if (mem_write && !w_ignore) begin
        if (w_hit) begin
          w_match_nxt = r_match_cnt + 1'b1;
          if (w_match_nxt == r_exp_cnt) begin
            w_state_nxt = ST_PASS;
          end
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
      // A decided run on the last allowed cycle beats the timeout, and the
      // counter freezes on whichever edge ends the run.
      if (w_state_nxt == ST_ARMED) begin
        if (r_cycles == TO_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end else if (r_cycles != '1) begin
          w_cycles_nxt = r_cycles + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_exp_cnt   <= '0;
      r_cycles    <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_cycles    <= w_cycles_nxt;
      if (w_start_go) begin
        r_exp_cnt <= w_cnt_clip;
      end
      r_pass      <= (w_state_nxt == ST_PASS);
      r_fail      <= (w_state_nxt == ST_FAIL);
      r_timeout   <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign done      = r_pass | r_fail | r_timeout;
  assign match_cnt = r_match_cnt;
  assign cycles    = r_cycles;
  assign dbg_state = r_state;

`ifdef MISMATCH_CAPTURE_EN
  logic [WIDTH-1:0] r_bad_adr;
  logic [WIDTH-1:0] r_bad_data;
  logic [IDX_W-1:0] r_bad_idx;

  always_ff @(posedge clk) begin
    if (!reset || w_start_go) begin
      r_bad_adr  <= '0;
      r_bad_data <= '0;
      r_bad_idx  <= '0;
    end else if ((r_state == ST_ARMED) && (w_state_nxt == ST_FAIL)) begin
      r_bad_adr  <= data_adr;
      r_bad_data <= write_data;
      r_bad_idx  <= r_match_cnt[IDX_W-1:0];
    end
  end

  assign bad_adr  = r_bad_adr;
  assign bad_data = r_bad_data;
  assign bad_idx  = r_bad_idx;
`else
  // Without capture, a failing run is reported through fail and match_cnt only.
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: directed and random runs against a
// sequence-level reference model; a negedge monitor checks each finished run.
`timescale 1ns/1ps
module tb_mem_write_monitor;
  import mon_pkg::*;

  localparam int W   = 32;
  localparam int D   = 4;
  localparam int TO  = 20;
  localparam int IGN = 96;
  localparam int CW  = 3;
  localparam int IW  = 2;
  localparam logic [1:0] R_PASS = 2'd1;
  localparam logic [1:0] R_FAIL = 2'd2;
  localparam logic [1:0] R_TO   = 2'd3;

  typedef struct packed {
    logic [1:0]    res;
    logic [CW-1:0] mcnt;
    logic [31:0]   cyc_v;
    logic [31:0]   edge_n;
    logic [W-1:0]  bad_a;
    logic [W-1:0]  bad_d;
    logic [IW-1:0] bad_i;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_write = 1'b0;
  logic [W-1:0]  data_adr = '0;
  logic [W-1:0]  write_data = '0;
  logic          exp_we = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [W-1:0]  exp_adr = '0;
  logic [W-1:0]  exp_data = '0;
  logic [CW-1:0] exp_count = '0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          done, pass, fail, timeout;
  logic [CW-1:0] match_cnt;
  logic [31:0]   cycles;
  mon_state_e    dbg_state;
`ifdef MISMATCH_CAPTURE_EN
  logic [W-1:0]  bad_adr, bad_data;
  logic [IW-1:0] bad_idx;
`endif

  always #5 clk = ~clk;

  mem_write_monitor #(
    .WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO), .IGNORE_EN(1), .IGNORE_ADR(32'(IGN))
  ) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_count(exp_count),
    .start(start), .clear(clear), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .match_cnt(match_cnt), .cycles(cycles),
    .dbg_state(dbg_state)
`ifdef MISMATCH_CAPTURE_EN
    , .bad_adr(bad_adr), .bad_data(bad_data), .bad_idx(bad_idx)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench state ----------------
  int           n_tests = 0;
  int           n_fail = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic         prev_done = 1'b0;
  logic [W-1:0] m_adr [D];
  logic [W-1:0] m_dat [D];
  logic         wr_v [TO];
  logic [W-1:0] wr_a [TO];
  logic [W-1:0] wr_d [TO];
  int           we_k = -1;
  logic [W-1:0] we_adr = '0;
  logic [W-1:0] we_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk the per-cycle write list in order against the table.
  function automatic exp_t model(input int cnt_in, output int k_dec);
    exp_t e;
    int cnt;
    int m;
    e = '0;
    cnt = (cnt_in > D) ? D : cnt_in;
    m = 0;
    k_dec = TO - 1;
    if (cnt == 0) begin
      e.res = R_PASS;
      k_dec = -1;
      return e;
    end
    for (int k = 0; k < TO; k++) begin
      if (wr_v[k] && (wr_a[k] != 32'(IGN))) begin
        if ((wr_a[k] == m_adr[m]) && (wr_d[k] == m_dat[m])) begin
          m++;
          if (m == cnt) begin
            e.res = R_PASS; e.mcnt = CW'(m); e.cyc_v = 32'(k); k_dec = k;
            return e;
          end
        end else begin
          e.res = R_FAIL; e.mcnt = CW'(m); e.cyc_v = 32'(k); k_dec = k;
          e.bad_a = wr_a[k]; e.bad_d = wr_d[k]; e.bad_i = IW'(m);
          return e;
        end
      end
      if (k == TO - 1) begin
        e.res = R_TO; e.mcnt = CW'(m); e.cyc_v = 32'(k); k_dec = k;
        return e;
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no run outstanding (required 0)");
      end else begin
        mon_e = exp_q.pop_front();
        check("pass",      64'(pass),      64'(mon_e.res == R_PASS));
        check("fail",      64'(fail),      64'(mon_e.res == R_FAIL));
        check("timeout",   64'(timeout),   64'(mon_e.res == R_TO));
        check("state",     64'(dbg_state), (mon_e.res == R_PASS) ? 64'(ST_PASS) :
                                           (mon_e.res == R_FAIL) ? 64'(ST_FAIL) : 64'(ST_TIMEOUT));
        check("match_cnt", 64'(match_cnt), 64'(mon_e.mcnt));
        check("cycles",    64'(cycles),    64'(mon_e.cyc_v));
        check("latency",   64'(cyc),       64'(mon_e.edge_n));
`ifdef MISMATCH_CAPTURE_EN
        check("bad_adr",   64'(bad_adr),   64'(mon_e.bad_a));
        check("bad_data",  64'(bad_data),  64'(mon_e.bad_d));
        check("bad_idx",   64'(bad_idx),   64'(mon_e.bad_i));
`endif
      end
    end
    prev_done <= done;
  end

  // ---------------- driver tasks ----------------
  task automatic clr_stim();
    for (int k = 0; k < TO; k++) begin
      wr_v[k] = 1'b0; wr_a[k] = '0; wr_d[k] = '0;
    end
    we_k = -1;
  endtask

  task automatic set_wr(input int k, input logic [W-1:0] a, input logic [W-1:0] d);
    wr_v[k] = 1'b1; wr_a[k] = a; wr_d[k] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < D; i++) begin
      m_adr[i] = '0; m_dat[i] = '0;
    end
    check("rst_done",    64'(done),      64'd0);
    check("rst_pass",    64'(pass),      64'd0);
    check("rst_fail",    64'(fail),      64'd0);
    check("rst_timeout", 64'(timeout),   64'd0);
    check("rst_match",   64'(match_cnt), 64'd0);
    check("rst_cycles",  64'(cycles),    64'd0);
    check("rst_state",   64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_done",  64'(done),      64'd0);
    check("clear_state", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic load(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    exp_we = 1'b1; exp_idx = IW'(idx); exp_adr = a; exp_data = d;
    @(negedge clk);
    exp_we = 1'b0;
    m_adr[idx] = a;
    m_dat[idx] = d;
  endtask

  task automatic do_run(input int cnt_in);
    exp_t e;
    int kd;
    e = model(cnt_in, kd);
    @(negedge clk);
    start = 1'b1;
    exp_count = CW'(cnt_in);
    e.edge_n = 32'(cyc + 2 + kd);
    exp_q.push_back(e);
    for (int k = 0; k <= kd; k++) begin
      @(negedge clk);
      start = 1'b0;
      mem_write = wr_v[k]; data_adr = wr_a[k]; write_data = wr_d[k];
      exp_we = (k == we_k); exp_idx = '0; exp_adr = we_adr; exp_data = we_dat;
    end
    @(negedge clk);
    start = 1'b0; mem_write = 1'b0; exp_we = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: %0d runs without done flag (required 0)", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic gen_random();
    int g;
    int r;
    clr_stim();
    g = 0;
    for (int k = 0; k < TO; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 4) begin
        set_wr(k, 32'(IGN), 32'($urandom_range(0, 15)));
      end else if (r == 5) begin
        set_wr(k, 32'($urandom_range(0, 63) * 4), 32'($urandom_range(0, 15)));
      end else if (r >= 6) begin
        set_wr(k, m_adr[g % D], m_dat[g % D]);
        g++;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clr_stim();
    repeat (2) @(negedge clk);
    do_reset();

    // Ignored scratch write then the expected write.
    load(0, 32'd100, 32'd7);
    set_wr(0, 32'd96, 32'd3);
    set_wr(1, 32'd100, 32'd7);
    do_run(1);

    // Wrong address mismatches.
    do_clear();
    clr_stim();
    set_wr(0, 32'd104, 32'd7);
    do_run(1);

    // No writes at all: timeout after TO armed cycles.
    do_clear();
    clr_stim();
    do_run(1);

    // Table write attempted while ARMED must not land.
    do_clear();
    clr_stim();
    we_k = 0; we_adr = 32'd200; we_dat = 32'd9;
    set_wr(1, 32'd100, 32'd7);
    do_run(1);

    // Four-entry table in order, then rerun from PASS with 3rd/4th swapped.
    do_clear();
    load(0, 32'd0, 32'd1);
    load(1, 32'd4, 32'd2);
    load(2, 32'd8, 32'd3);
    load(3, 32'd12, 32'd4);
    clr_stim();
    set_wr(0, 32'd0, 32'd1); set_wr(1, 32'd4, 32'd2);
    set_wr(2, 32'd8, 32'd3); set_wr(3, 32'd12, 32'd4);
    do_run(4);
    clr_stim();
    set_wr(0, 32'd0, 32'd1); set_wr(1, 32'd4, 32'd2);
    set_wr(2, 32'd12, 32'd4); set_wr(3, 32'd8, 32'd3);
    do_run(4);

    // Final match lands on the last allowed cycle.
    do_clear();
    clr_stim();
    set_wr(10, 32'd0, 32'd1); set_wr(13, 32'd4, 32'd2);
    set_wr(16, 32'd8, 32'd3); set_wr(TO - 1, 32'd12, 32'd4);
    do_run(4);

    // Over-range count is clipped to the table depth.
    do_clear();
    clr_stim();
    set_wr(0, 32'd0, 32'd1); set_wr(1, 32'd4, 32'd2);
    set_wr(2, 32'd8, 32'd3); set_wr(3, 32'd12, 32'd4);
    do_run(7);

    // Reset in the middle of an armed run after two matches.
    do_clear();
    @(negedge clk);
    start = 1'b1; exp_count = 3'd4;
    @(negedge clk);
    start = 1'b0; mem_write = 1'b1; data_adr = 32'd0; write_data = 32'd1;
    @(negedge clk);
    data_adr = 32'd4; write_data = 32'd2;
    @(negedge clk);
    mem_write = 1'b0;
    check("pre_reset_match", 64'(match_cnt), 64'd2);
    check("pre_reset_state", 64'(dbg_state), 64'(ST_ARMED));
    do_reset();
    // Every table entry must read back as zero.
    clr_stim();
    for (int k = 0; k < D; k++) set_wr(k, 32'd0, 32'd0);
    do_run(4);

    // Random tables, counts and write streams.
    for (int r = 0; r < 30; r++) begin
      do_clear();
      for (int i = 0; i < D; i++) begin
        load(i, 32'($urandom_range(0, 63) * 4), 32'($urandom_range(0, 15)));
      end
      gen_random();
      do_run(int'($urandom_range(0, 5)));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary (required normal end)");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
Synthesizable, parametrised successor to the processor pass/fail bench check. Watches the data-memory write port of the multi-cycle core and matches writes against a loadable ordered table of expected (address, data) pairs. One scratch address can be ignored, and a cycle timeout bounds the run. Sits beside `top` in simulation and FPGA self-test builds, and drives sticky pass/fail/timeout flags.

Parameters:
WIDTH, 32, address and data width of the monitored bus
DEPTH, 4, number of expected-write table entries (>=1)
TIMEOUT_CYCLES, 1000, ARMED cycles allowed before timeout (>=2)
IGNORE_EN, 1, 1 = writes to IGNORE_ADR are skipped without checking
IGNORE_ADR, 96, address whose writes are ignored when IGNORE_EN=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
mem_write  in  1  core MemWrite strobe
data_adr  in  WIDTH  core DataAdr
write_data  in  WIDTH  core WriteData
exp_we  in  1  table write enable, honoured in IDLE only
exp_idx  in  clog2(DEPTH) (min 1)  table entry index
exp_adr  in  WIDTH  expected address for entry
exp_data  in  WIDTH  expected data for entry
exp_count  in  clog2(DEPTH+1)  entries to check, sampled on start
start  in  1  arm the monitor
clear  in  1  return to IDLE from any non-IDLE state
done  out  1  state is PASS, FAIL or TIMEOUT
pass  out  1  all exp_count writes matched in order
fail  out  1  a checked write mismatched
timeout  out  1  TIMEOUT_CYCLES elapsed without completion
match_cnt  out  clog2(DEPTH+1)  entries matched so far
cycles  out  32  ARMED cycle counter, saturating at all-ones

Behaviour:
- Reset: at a clk edge with reset=0, state=IDLE. done, pass, fail, timeout, match_cnt and cycles are 0. Table entries are cleared to 0. This applies mid-run from any state.
- States: IDLE, ARMED, PASS, FAIL, TIMEOUT. pass, fail and timeout are registered decodes of state. done = pass | fail | timeout.
- Table loading (IDLE): at an edge with exp_we=1, entry[exp_idx] <= {exp_adr, exp_data}. If exp_idx >= DEPTH, the write is dropped. exp_we has no effect outside IDLE.
- IDLE or a terminal state, start=1:
  - Latch min(exp_count, DEPTH).
  - Set match_cnt=0 and cycles=0, then go to ARMED.
  - If the latched count is 0, go directly to PASS.
- Priority: clear beats start. In ARMED, start is ignored.
- ARMED, once per cycle, first matching rule wins:
  1. mem_write=0: no check.
  2. IGNORE_EN=1 and data_adr==IGNORE_ADR: no check.
  3. data_adr==entry[match_cnt].adr and write_data==entry[match_cnt].data: match_cnt+1. If that was the last entry, next state is PASS.
  4. Otherwise: next state is FAIL and match_cnt holds.
- Timeout: cycles increments every ARMED cycle. If cycles==TIMEOUT_CYCLES-1 and the cycle produces no PASS/FAIL transition, next state is TIMEOUT.
- Same-cycle events: a final match or a mismatch on the timeout cycle takes precedence, so the result is PASS or FAIL, not TIMEOUT.
- Checking takes one sample per rising edge. A write held high over N edges counts N times; the core holds MemWrite for a single cycle.
- Latency: the flag is visible in the cycle after the deciding edge.
- Terminal states are sticky until start, clear or reset. Outputs hold their values; cycles stops counting.
- All compares are exact WIDTH-bit equality. No X/Z semantics.

Optional Feature:
MISMATCH_CAPTURE_EN
- Defined: adds outputs bad_adr, bad_data (WIDTH each) and bad_idx (clog2(DEPTH) bits).
  - Loaded on the ARMED->FAIL edge with data_adr, write_data and match_cnt.
  - Cleared by reset and by start.
  - Hold their values otherwise.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mon_pkg:
  - state enum (IDLE=0, ARMED=1, PASS=2, FAIL=3, TIMEOUT=4, 3-bit encoding)
  - table entry struct {adr, data}
  - default IGNORE_ADR constant
- One sub-module, mon_exp_table: DEPTH-entry register file with synchronous write, combinational read at match_cnt, and synchronous active-low clear.

Test Plan:
1. Load entry0={100,7}, exp_count=1, start. Write (96,3), then (100,7) -> pass=1 one cycle after the second write, match_cnt=1, fail=0.
2. Same table; write (104,7) -> fail=1, match_cnt=0. With MISMATCH_CAPTURE_EN: bad_adr=104, bad_data=7, bad_idx=0.
3. TIMEOUT_CYCLES=20, no writes -> timeout=1 after exactly 20 ARMED cycles; cycles=19 held.
4. DEPTH=4 with table {(0,1),(4,2),(8,3),(12,4)}, exp_count=4:
   - Writes in order -> pass.
   - Rerun with start, swapping the 3rd and 4th writes -> fail with match_cnt=2.
5. Final matching write on cycle TIMEOUT_CYCLES-1 -> pass, not timeout.
6. Drive reset=0 mid-ARMED after 2 matches -> next cycle all outputs 0, state IDLE, and table reads 0. Also check that exp_we in ARMED leaves the table unchanged.
